// File: rtl/rvh_noc_pkg.sv
// rvh_noc_pkg: shared NoC types plus DAMQ slot-index helpers; shared pool gated by INPUT_PORT_DAMQ_SHARED_POOL_EN.
package rvh_noc_pkg;
  localparam int VC_ID_NUM_MAX_W = 4;
  localparam int DAMQ_SLOT_IDX_MAX_W = 8;
  typedef struct packed {
    logic [3:0] src_id;
    logic [2:0] opcode;
    logic       tail;
  } flit_dec_t;
  typedef logic [DAMQ_SLOT_IDX_MAX_W-1:0] damq_slot_idx_t;
  function automatic int damq_slot_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
`ifdef INPUT_PORT_DAMQ_SHARED_POOL_EN
  localparam bit DAMQ_SHARED_POOL_EN = 1'b1;
`else
  localparam bit DAMQ_SHARED_POOL_EN = 1'b0;
`endif
endpackage

// File: rtl/freelist.sv
// freelist: circular FIFO of free slot indices, holding every index 0..ENTRY_COUNT-1 after reset.
module freelist
  import rvh_noc_pkg::*;
#(
  parameter int ENTRY_COUNT = 8,
  localparam int IDX_W = damq_slot_w(ENTRY_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_i,
  output logic             alloc_vld_o,
  output logic [IDX_W-1:0] alloc_idx_o,
  input  logic             free_i,
  input  logic [IDX_W-1:0] free_idx_i
);
  logic [IDX_W-1:0] fifo_q [ENTRY_COUNT];
  logic [IDX_W-1:0] rd_q, wr_q;
  logic [IDX_W:0]   cnt_q;
  logic             do_pop;
  function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(ENTRY_COUNT - 1)) ? '0 : p + 1'b1;
  endfunction
  assign alloc_vld_o = cnt_q != '0;
  assign alloc_idx_o = fifo_q[rd_q];
  assign do_pop      = alloc_i && alloc_vld_o;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_COUNT; i++) fifo_q[i] <= IDX_W'(i);
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= (IDX_W+1)'(ENTRY_COUNT);
    end else begin
      if (free_i) begin
        fifo_q[wr_q] <= free_idx_i;
        wr_q         <= inc(wr_q);
      end
      if (do_pop) rd_q <= inc(rd_q);
      cnt_q <= cnt_q + (IDX_W+1)'(free_i) - (IDX_W+1)'(do_pop);
    end
  end
endmodule

// File: rtl/input_port_damq.sv
// input_port_damq: dynamically allocated multi-queue input buffer with per-VC linked lists and credit return.
// Optional shared pool enabled by INPUT_PORT_DAMQ_SHARED_POOL_EN; otherwise each VC is capped at VC_RSV_DEPTH.
module input_port_damq
  import rvh_noc_pkg::*;
#(
  parameter type flit_payload_t = logic [256-1:0],
  parameter int  VC_NUM         = 4,
  parameter int  VC_RSV_DEPTH   = 2,
  parameter int  SHARED_DEPTH   = 4,
  localparam int SHARED_EFF     = DAMQ_SHARED_POOL_EN ? SHARED_DEPTH : 0,
  localparam int TOTAL_DEPTH    = VC_NUM * VC_RSV_DEPTH + SHARED_EFF,
  localparam int SLOT_W         = damq_slot_w(TOTAL_DEPTH),
  localparam int VC_IDX_W       = damq_slot_w(VC_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flit_v_i,
  input  flit_payload_t              flit_i,
  input  flit_dec_t                  flit_dec_i,
  input  logic [VC_IDX_W-1:0]        flit_vc_id_i,
  output logic [VC_NUM-1:0]          vc_ctrl_head_vld_o,
  output flit_dec_t                  vc_ctrl_head_o [VC_NUM],
  output flit_payload_t              vc_data_head_o [VC_NUM],
  input  logic                       deq_v_i,
  input  logic [VC_IDX_W-1:0]        deq_vc_id_i,
  output logic                       lcrd_v_o,
  output logic [VC_ID_NUM_MAX_W-1:0] lcrd_id_o,
  output logic                       lcrd_shared_o,
  output logic [SLOT_W:0]            vc_occ_o [VC_NUM],
  output logic                       err_o
);
  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [SLOT_W:0]   occ_t;
  flit_payload_t              data_q [TOTAL_DEPTH];
  flit_dec_t                  ctrl_q [TOTAL_DEPTH];
  slot_t                      next_q [TOTAL_DEPTH];
  slot_t                      head_q [VC_NUM];
  slot_t                      tail_q [VC_NUM];
  occ_t                       occ_q  [VC_NUM];
  logic                       lcrd_v_q, lcrd_shared_q, err_q;
  logic [VC_ID_NUM_MAX_W-1:0] lcrd_id_q;
  logic                       fl_vld, enq_vc_ok, deq_vc_ok, enq_ok, deq_ok;
  logic                       same_vc, enq_to_head, deq_shared, shared_full;
  slot_t                      fl_idx;
  occ_t                       enq_occ, shared_used;
  if ((1 << VC_IDX_W) == VC_NUM) begin : g_pow2
    assign enq_vc_ok = 1'b1;
    assign deq_vc_ok = 1'b1;
  end else begin : g_npow2
    assign enq_vc_ok = 32'(flit_vc_id_i) < VC_NUM;
    assign deq_vc_ok = 32'(deq_vc_id_i) < VC_NUM;
  end
  // Shared usage is derived from occupancies so it can never drift from the lists.
  always_comb begin
    shared_used = '0;
    for (int v = 0; v < VC_NUM; v++)
      shared_used = shared_used + ((occ_q[v] > occ_t'(VC_RSV_DEPTH)) ? occ_q[v] - occ_t'(VC_RSV_DEPTH) : '0);
  end
  assign shared_full = shared_used == occ_t'(SHARED_EFF);
  assign enq_occ     = occ_q[flit_vc_id_i];
  assign deq_ok      = deq_v_i && deq_vc_ok && occ_q[deq_vc_id_i] != '0;
  assign enq_ok      = flit_v_i && enq_vc_ok && fl_vld && (enq_occ < occ_t'(VC_RSV_DEPTH) || !shared_full);
  assign same_vc     = flit_vc_id_i == deq_vc_id_i;
  assign enq_to_head = enq_occ == '0 || (deq_ok && same_vc && enq_occ == occ_t'(1));
`ifdef INPUT_PORT_DAMQ_SHARED_POOL_EN
  assign deq_shared = occ_q[deq_vc_id_i] > occ_t'(VC_RSV_DEPTH);
`else
  assign deq_shared = 1'b0;
`endif
  freelist #(
    .ENTRY_COUNT (TOTAL_DEPTH)
  ) u_freelist (
    .clk         (clk),
    .rst         (rst),
    .alloc_i     (enq_ok),
    .alloc_vld_o (fl_vld),
    .alloc_idx_o (fl_idx),
    .free_i      (deq_ok),
    .free_idx_i  (head_q[deq_vc_id_i])
  );
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      data_q[fl_idx] <= flit_i;
      ctrl_q[fl_idx] <= flit_dec_i;
      if (!enq_to_head) next_q[tail_q[flit_vc_id_i]] <= fl_idx;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) begin
        head_q[v] <= '0;
        tail_q[v] <= '0;
        occ_q[v]  <= '0;
      end
      lcrd_v_q      <= 1'b0;
      lcrd_id_q     <= '0;
      lcrd_shared_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // A one-entry VC dequeued while enqueued hands its head straight to the new slot.
      if (deq_ok && !(enq_ok && same_vc && enq_to_head)) head_q[deq_vc_id_i] <= next_q[head_q[deq_vc_id_i]];
      if (enq_ok) begin
        tail_q[flit_vc_id_i] <= fl_idx;
        if (enq_to_head) head_q[flit_vc_id_i] <= fl_idx;
      end
      for (int v = 0; v < VC_NUM; v++)
        occ_q[v] <= occ_q[v] + occ_t'(enq_ok && flit_vc_id_i == VC_IDX_W'(v))
                             - occ_t'(deq_ok && deq_vc_id_i == VC_IDX_W'(v));
      lcrd_v_q      <= deq_ok;
      lcrd_id_q     <= deq_ok ? VC_ID_NUM_MAX_W'(deq_vc_id_i) : '0;
      lcrd_shared_q <= deq_ok && deq_shared;
      err_q         <= err_q || (flit_v_i && !enq_ok) || (deq_v_i && !deq_ok);
    end
  end
  always_comb begin
    for (int v = 0; v < VC_NUM; v++) begin
      vc_ctrl_head_vld_o[v] = occ_q[v] != '0;
      vc_ctrl_head_o[v]     = ctrl_q[head_q[v]];
      vc_data_head_o[v]     = data_q[head_q[v]];
      vc_occ_o[v]           = occ_q[v];
    end
  end
  assign lcrd_v_o      = lcrd_v_q;
  assign lcrd_id_o     = lcrd_id_q;
  assign lcrd_shared_o = lcrd_shared_q;
  assign err_o         = err_q;
endmodule
